digit_serial_adder: RTL

- Sequential front/back end for the 4-bit prefix adder slice. Adds two WIDTH-bit operands, 4 bits per cycle.
- Feeds one nibble pair plus carry into the slice each cycle. Captures the slice's sum and carry-out into a result register.
- Upstream and downstream sides use valid/ready handshakes. One external slice instance serves any operand width.

---
 rtl/digit_serial_adder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: adds two WIDTH-bit operands four bits per cycle by
// sequencing nibble pairs through an external combinational 4-bit adder
// slice. Upstream and downstream sides use valid/ready handshakes.
// Optional feature macro: DIGIT_SERIAL_ADDER_SIGNED_OVF_EN adds out_ovf,
// the two's-complement overflow flag of the completed add.
module digit_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
`ifdef DIGIT_SERIAL_ADDER_SIGNED_OVF_EN
    output logic             out_ovf,
`endif
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    input  logic [3:0]       slice_sum,
    input  logic             slice_cout
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    // Reject widths the nibble sequencing cannot cover.
    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
        $error("digit_serial_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  a_reg, b_reg, sum_reg;
    logic              carry;
    logic [IW-1:0]     idx;
    logic              cout_reg;
    logic              accept;
    logic              last_pass;

    assign accept    = in_valid & in_ready;
    assign last_pass = (state == RUN) && (idx == LAST_IDX);
    assign out_sum   = sum_reg;
    assign out_cout  = cout_reg;

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus handshake and slice-drive outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        slice_a    = 4'h0;
        slice_b    = 4'h0;
        slice_cin  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                slice_a   = a_reg[int'(idx) * 4 +: 4];
                slice_b   = b_reg[int'(idx) * 4 +: 4];
                slice_cin = carry;
                if (last_pass) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                // A waiting request starts immediately, no IDLE bubble.
                if (out_ready) state_next = in_valid ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture on accept; one nibble of sum and the ripple carry per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            cout_reg <= 1'b0;
        end else if (accept) begin
            a_reg <= in_a;
            b_reg <= in_b;
            carry <= in_cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum_reg[int'(idx) * 4 +: 4] <= slice_sum;
            carry <= slice_cout;
            if (last_pass) begin
                idx      <= '0;
                cout_reg <= slice_cout;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

`ifdef DIGIT_SERIAL_ADDER_SIGNED_OVF_EN
    logic ovf_reg;
    assign out_ovf = ovf_reg;

    // Overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (last_pass) begin
            ovf_reg <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ slice_sum[3] ^ slice_cout;
        end
    end
`endif

endmodule
